// File: rtl/image_scaler_if.sv
// rtl/image_scaler_if.sv - source ROM read / destination RAM write bus of the image scaler
//
// Purpose: groups the ROM read port and RAM write port used by image_scaler.
// Signals:
//   rom_addr   source read address (scaler -> ROM)
//   rom_data   ROM read data, one cycle after rom_addr (ROM -> scaler)
//   ram_wraddr destination write address (scaler -> RAM)
//   ram_data   destination write data (scaler -> RAM)
//   ram_wren   destination write strobe (scaler -> RAM)
// Modports: master = scaler side, slave = memory side.
interface image_scaler_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_wren;

  modport master (
    output rom_addr,
    input  rom_data,
    output ram_wraddr,
    output ram_data,
    output ram_wren
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ram_wraddr,
    input  ram_data,
    input  ram_wren
  );
endinterface

// File: rtl/image_scaler.sv
// rtl/image_scaler.sv - ROM-to-RAM frame scaler: copy, NN zoom-in, decimate, block average
//
// Purpose: reads a SRC_W x SRC_H frame from a synchronous ROM and writes the
// scaled frame, row-major, to a RAM. Factor F = 1<<k, k in 0..2.
// Ports:
//   clk, reset (async, active-low)
//   start        one-cycle launch, accepted in IDLE or DONE
//   mode         0 copy, 1 zoom-in, 2 decimate, 3 block average (latched)
//   factor_log2  k, 3 clamps to 2 (latched)
//   busy, done   frame status
//   mem          image_scaler_if master: rom_addr/rom_data, ram_wraddr/ram_data/ram_wren
// Optional: define IMAGE_SCALER_ROUND_EN for round-half-up in block-average mode.
module image_scaler #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [1:0]  factor_log2,
  output logic        busy,
  output logic        done,
  image_scaler_if.master mem
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] SW = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] SH = ADDR_W'(SRC_H);

  state_t            state, state_nx;
  logic [1:0]        mode_q, k_q, k_in;
  logic [ADDR_W-1:0] ox, oy, out_idx, dw_m1, dh_m1, src_addr;
  logic [1:0]        dx, dy, f_m1;
  logic [2:0]        f, sh2;
  logic              accept, issue, is_zoom, is_avg, block_last, frame_last;
  logic              p1_valid, p1_last, p1_final, wr_final;
  logic [ADDR_W-1:0] p1_idx;
  logic [PIX_W+3:0]  acc, sum, avg_val;

  assign accept  = start && (state == IDLE || state == DONE);
  assign k_in    = (mode == 2'd0) ? 2'd0 : ((factor_log2 == 2'd3) ? 2'd2 : factor_log2);
  assign is_zoom = (mode_q < 2'd2);  // copy is zoom with k forced to 0
  assign is_avg  = (mode_q == 2'd3);
  assign f       = 3'd1 << k_q;
  assign f_m1    = 2'(f - 3'd1);
  assign sh2     = {k_q, 1'b0};
  assign dw_m1   = (is_zoom ? (SW << k_q) : (SW >> k_q)) - 1'b1;
  assign dh_m1   = (is_zoom ? (SH << k_q) : (SH >> k_q)) - 1'b1;
  assign issue   = (state == RUN);

  // Only average mode walks the F x F block; every other read completes a pixel.
  assign block_last = !is_avg || (dx == f_m1 && dy == f_m1);
  assign frame_last = block_last && ox == dw_m1 && oy == dh_m1;

  always_comb begin
    src_addr = '0;
    if (is_zoom)
      src_addr = (oy >> k_q) * SW + (ox >> k_q);
    else
      src_addr = ((oy << k_q) + ADDR_W'(dy)) * SW + (ox << k_q) + ADDR_W'(dx);
  end

  assign mem.rom_addr = issue ? src_addr : '0;

  // Accumulated block sum including the word arriving this cycle.
  assign sum = acc + (PIX_W+4)'(mem.rom_data);
`ifdef IMAGE_SCALER_ROUND_EN
  assign avg_val = (k_q == 2'd0) ? sum : ((sum + ((PIX_W+4)'(1) << (sh2 - 3'd1))) >> sh2);
`else
  assign avg_val = sum >> sh2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (frame_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (mem.ram_wren && wr_final) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Issue-side counters: destination pixel (ox, oy) and block offset (dx, dy).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= '0; k_q <= '0;
      ox <= '0; oy <= '0; dx <= '0; dy <= '0; out_idx <= '0;
    end else if (accept) begin
      mode_q <= mode; k_q <= k_in;
      ox <= '0; oy <= '0; dx <= '0; dy <= '0; out_idx <= '0;
    end else if (issue) begin
      if (!block_last) begin
        if (dx == f_m1) begin
          dx <= '0;
          dy <= dy + 2'd1;
        end else begin
          dx <= dx + 2'd1;
        end
      end else begin
        dx      <= '0;
        dy      <= '0;
        out_idx <= out_idx + 1'b1;
        if (ox == dw_m1) begin
          ox <= '0;
          oy <= oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

  // p1 tracks the read whose data is on rom_data this cycle; the write
  // register stage below makes the write land 2 cycles after its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_valid <= 1'b0; p1_last <= 1'b0; p1_final <= 1'b0; p1_idx <= '0;
      acc <= '0; wr_final <= 1'b0;
      mem.ram_wren <= 1'b0; mem.ram_wraddr <= '0; mem.ram_data <= '0;
    end else begin
      p1_valid     <= issue;
      p1_last      <= block_last;
      p1_final     <= frame_last;
      p1_idx       <= out_idx;
      mem.ram_wren <= p1_valid && p1_last;
      if (p1_valid && is_avg)
        acc <= p1_last ? '0 : sum;
      if (p1_valid && p1_last) begin
        mem.ram_wraddr <= p1_idx;
        mem.ram_data   <= is_avg ? avg_val[PIX_W-1:0] : mem.rom_data;
        wr_final       <= p1_final;
      end
    end
  end

endmodule

// File: tb/tb_image_scaler.sv
// tb/tb_image_scaler.sv - self-checking bench for image_scaler (three small frame geometries)
module tb_image_scaler;

  typedef struct {
    int inst;
    int addr;
    int data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] start = 3'b000;
  logic [1:0] mode = 2'd0;
  logic [1:0] fk = 2'd0;
  wire  [2:0] busy, done;

  int   vectors = 0;
  int   miscompares = 0;
  int   nwr[3] = '{0, 0, 0};
  exp_t sb[$];

  always #5 clk = ~clk;

  image_scaler_if #(.ADDR_W(8), .PIX_W(8)) ifa ();
  image_scaler_if #(.ADDR_W(8), .PIX_W(8)) ifb ();
  image_scaler_if #(.ADDR_W(8), .PIX_W(8)) ifc ();

  image_scaler #(.SRC_W(4), .SRC_H(2), .PIX_W(8), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode), .factor_log2(fk),
    .busy(busy[0]), .done(done[0]), .mem(ifa));
  image_scaler #(.SRC_W(4), .SRC_H(4), .PIX_W(8), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode), .factor_log2(fk),
    .busy(busy[1]), .done(done[1]), .mem(ifb));
  image_scaler #(.SRC_W(2), .SRC_H(2), .PIX_W(8), .ADDR_W(8)) dut_c (
    .clk(clk), .reset(reset), .start(start[2]), .mode(mode), .factor_log2(fk),
    .busy(busy[2]), .done(done[2]), .mem(ifc));

  function automatic int rom_val(input int inst, input int a);
    if (inst < 2) return a & 8'hff;
    case (a)
      0: return 10;
      1: return 11;
      2: return 12;
      3: return 14;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    ifa.rom_data <= 8'(rom_val(0, int'(ifa.rom_addr)));
    ifb.rom_data <= 8'(rom_val(1, int'(ifb.rom_addr)));
    ifc.rom_data <= 8'(rom_val(2, int'(ifc.rom_addr)));
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_write(input int inst, input logic wren, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    if (wren === 1'b1) begin
      nwr[inst]++;
      chk("write_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write_inst", inst, e.inst);
        chk("write_addr", int'(a), e.addr);
        chk("write_data", int'(d), e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    check_write(0, ifa.ram_wren, ifa.ram_wraddr, ifa.ram_data);
    check_write(1, ifb.ram_wren, ifb.ram_wraddr, ifb.ram_data);
    check_write(2, ifc.ram_wren, ifc.ram_wraddr, ifc.ram_data);
  end

  // Reference model: direct per-pixel formulas, pushed in destination raster order.
  task automatic expect_frame(input int inst, input int sw, input int sh, input int md, input int fkv);
    int k, f, dw, dh, v, s;
    exp_t e;
    k = (md == 0) ? 0 : ((fkv > 2) ? 2 : fkv);
    f = 1 << k;
    dw = (md <= 1) ? sw * f : sw / f;
    dh = (md <= 1) ? sh * f : sh / f;
    for (int oy = 0; oy < dh; oy++) begin
      for (int ox = 0; ox < dw; ox++) begin
        if (md <= 1) v = rom_val(inst, (oy / f) * sw + ox / f);
        else if (md == 2) v = rom_val(inst, oy * f * sw + ox * f);
        else begin
          s = 0;
          for (int by = 0; by < f; by++)
            for (int bx = 0; bx < f; bx++)
              s += rom_val(inst, (oy * f + by) * sw + ox * f + bx);
`ifdef IMAGE_SCALER_ROUND_EN
          v = (k > 0) ? (s + (f * f) / 2) / (f * f) : s;
`else
          v = s / (f * f);
`endif
        end
        e.inst = inst;
        e.addr = oy * dw + ox;
        e.data = v;
        sb.push_back(e);
      end
    end
  endtask

  function automatic logic wren_of(input int inst);
    case (inst)
      0: return ifa.ram_wren;
      1: return ifb.ram_wren;
      default: return ifc.ram_wren;
    endcase
  endfunction

  // Leaves the bench at 1 time unit after the edge that accepts start (cycle 1).
  task automatic launch(input int inst, input int md, input int fkv);
    @(posedge clk);
    #1;
    mode = 2'(md);
    fk = 2'(fkv);
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget, output int first, output int last, output int cyc);
    first = -1;
    last = -1;
    cyc = 1;
    while (cyc <= budget) begin
      if (wren_of(inst) === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (done[inst] === 1'b1) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_within_budget", int'(done[inst] === 1'b1), 1);
  endtask

  function automatic int outs_a();
    return int'(ifa.rom_addr) | int'(ifa.ram_wraddr) | int'(ifa.ram_data)
         | int'(ifa.ram_wren) | int'(busy[0]) | int'(done[0]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, cyc, n0;

    #1;
    chk("reset_outputs_a", outs_a(), 0);
    chk("reset_busy_done", int'({busy, done}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Copy 4x2
    expect_frame(0, 4, 2, 0, 0);
    n0 = nwr[0];
    launch(0, 0, 0);
    chk("copy_busy_cycle1", int'(busy[0]), 1);
    wait_done(0, 100, first, last, cyc);
    chk("copy_first_wren_cycle", first, 3);
    chk("copy_back_to_back_span", last - first + 1, 8);
    chk("copy_write_count", nwr[0] - n0, 8);
    chk("copy_done_after_last", cyc, last + 1);
    chk("copy_sb_empty", sb.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("copy_done_held", int'(done[0]), 1);
    chk("copy_busy_low", int'(busy[0]), 0);
    chk("copy_no_extra_writes", nwr[0] - n0, 8);

    // Zoom-in x2
    expect_frame(0, 4, 2, 1, 1);
    n0 = nwr[0];
    launch(0, 1, 1);
    wait_done(0, 200, first, last, cyc);
    chk("zoom_write_count", nwr[0] - n0, 32);
    chk("zoom_span", last - first + 1, 32);
    chk("zoom_sb_empty", sb.size(), 0);

    // Decimate 4x4 by 2
    expect_frame(1, 4, 4, 2, 1);
    n0 = nwr[1];
    launch(1, 2, 1);
    wait_done(1, 100, first, last, cyc);
    chk("dec_write_count", nwr[1] - n0, 4);
    chk("dec_first_wren_cycle", first, 3);
    chk("dec_sb_empty", sb.size(), 0);

    // Block average 2x2 by 2 (factor 3 clamps to 2 would empty the frame, so use 1)
    expect_frame(2, 2, 2, 3, 1);
    n0 = nwr[2];
    launch(2, 3, 1);
    wait_done(2, 100, first, last, cyc);
    chk("avg_write_count", nwr[2] - n0, 1);
    chk("avg_wren_one_cycle", last - first, 0);
    chk("avg_wren_cycle", first, 6);
    chk("avg_sb_empty", sb.size(), 0);

    // start while busy is ignored; start after done relaunches
    expect_frame(0, 4, 2, 1, 1);
    n0 = nwr[0];
    launch(0, 1, 1);
    repeat (4) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 200, first, last, cyc);
    chk("busy_start_write_count", nwr[0] - n0, 32);
    chk("busy_start_sb_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_no_rerun", nwr[0] - n0, 32);
    expect_frame(0, 4, 2, 1, 1);
    n0 = nwr[0];
    launch(0, 1, 1);
    chk("relaunch_done_drops", int'(done[0]), 0);
    chk("relaunch_busy_rises", int'(busy[0]), 1);
    wait_done(0, 200, first, last, cyc);
    chk("relaunch_write_count", nwr[0] - n0, 32);
    chk("relaunch_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-frame
    expect_frame(0, 4, 2, 1, 1);
    launch(0, 1, 1);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midreset_outputs_zero", outs_a(), 0);
    sb.delete();
    n0 = nwr[0];
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_no_writes", nwr[0] - n0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postreset_idle", int'({busy[0], done[0]}), 0);
    chk("postreset_no_writes", nwr[0] - n0, 0);
    expect_frame(0, 4, 2, 1, 1);
    launch(0, 1, 1);
    wait_done(0, 200, first, last, cyc);
    chk("rerun_write_count", nwr[0] - n0, 32);
    chk("rerun_first_wren_cycle", first, 3);
    chk("rerun_sb_empty", sb.size(), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
